// File: rtl/wbu_multi.sv
// Multi-lane write-back stage: formats load data, drops r0 and overwritten writes,
// registers per-lane register-file writes and counts retired lanes.
module wbu_multi #(
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      mem_lane_valid,
  input  logic [32*LANES-1:0]   mem_alu_res,
  input  logic [32*LANES-1:0]   mem_r_data,
  input  logic [LANES-1:0]      mem_wb_sel,
  input  logic [3*LANES-1:0]    mem_ld_type,
  input  logic [2*LANES-1:0]    mem_addr_lo,
  input  logic [LANES-1:0]      mem_w_reg_ena,
  input  logic [5*LANES-1:0]    mem_w_reg_dst,
  output logic [LANES-1:0]      wb_w_reg_ena,
  output logic [5*LANES-1:0]    wb_w_reg_addr,
  output logic [32*LANES-1:0]   wb_w_reg_data,
  output logic [CNT_W-1:0]      retire_cnt
);

  logic [LANES-1:0]    w_req;
  logic [LANES-1:0]    w_ena;
  logic [32*LANES-1:0] w_data;
  logic [CNT_W-1:0]    w_pop;
  logic                w_accept;

  logic [LANES-1:0]    r_ena;
  logic [5*LANES-1:0]  r_addr;
  logic [32*LANES-1:0] r_data;
  logic [CNT_W-1:0]    r_cnt;

  function automatic logic [31:0] f_load(input logic [31:0] rd, input logic [2:0] ty,
                                         input logic [1:0] lo);
    logic [31:0] v_b;
    logic [31:0] v_h;
    v_b = rd >> {lo, 3'b000};
    v_h = rd >> {lo[1], 4'b0000};
    unique case (ty)
      3'd1:    return {{24{v_b[7]}}, v_b[7:0]};
      3'd2:    return {24'h0, v_b[7:0]};
      3'd3:    return {{16{v_h[15]}}, v_h[15:0]};
      3'd4:    return {16'h0, v_h[15:0]};
      default: return rd;
    endcase
  endfunction

  assign in_ready = ~stall;
  assign w_accept = in_valid & ~stall & ~flush;

  always_comb begin
    w_req  = '0;
    w_data = '0;
    w_pop  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_req[i] = mem_lane_valid[i] & mem_w_reg_ena[i] & (mem_w_reg_dst[5*i +: 5] != 5'd0);
      w_data[32*i +: 32] = mem_wb_sel[i]
                         ? f_load(mem_r_data[32*i +: 32], mem_ld_type[3*i +: 3],
                                  mem_addr_lo[2*i +: 2])
                         : mem_alu_res[32*i +: 32];
      w_pop = w_pop + CNT_W'(mem_lane_valid[i]);
    end
  end

  // A later lane writing the same register makes the earlier write dead.
  always_comb begin
    w_ena = w_req;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (w_req[j] && (mem_w_reg_dst[5*j +: 5] == mem_w_reg_dst[5*i +: 5])) begin
          w_ena[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ena  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else if (!stall) begin
      if (w_accept) begin
        r_ena  <= w_ena;
        r_addr <= mem_w_reg_dst;
        r_data <= w_data;
        r_cnt  <= r_cnt + w_pop;
      end else begin
        r_ena  <= '0;
      end
    end
  end

  assign wb_w_reg_ena  = r_ena;
  assign wb_w_reg_addr = r_addr;
  assign wb_w_reg_data = r_data;
  assign retire_cnt    = r_cnt;

endmodule
